lcd_state_sequencer: RTL and testbench

- Upstream feeder for the LCD controller: converts one-cycle game event pulses into the 8-bit display state code that the LCD controller renders.
- Owns all message timing. Transient messages are held for a programmed number of cycles, then the code reverts or advances automatically.
- Output is a clean registered code, so the LCD controller sees exactly one code change per event.

---
 rtl/lcd_state_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lcd_state_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_state_sequencer.sv
// Turns one-cycle game event pulses into the registered 8-bit display code for the LCD controller.
// Optional build macro LCD_AUTO_RESTART_EN: end codes hold for END_CYCLES, then return to auth pending.
//
// state   | meaning
// S_AUTH  | 00 waiting for credentials
// S_AOK   | 01 auth accepted, timed hold
// S_AFAIL | 02 auth rejected, timed hold
// S_PLAY  | 10 game in progress
// S_LHOLD | 11/12/13/14/16 level result, timed hold
// S_WIN   | 20 success begin, timed hold
// S_OVER  | 30 game-over begin, timed hold
// S_WEND  | 21 success end
// S_OEND  | 31 game-over end
module lcd_state_sequencer #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int END_CYCLES  = 150000000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auth_ok,
  input  logic       auth_fail,
  input  logic       level_pass,
  input  logic       level_fail,
  input  logic [1:0] level,
  input  logic       game_over,
  output logic [7:0] state,
  output logic       state_chg,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_AUTH, S_AOK, S_AFAIL, S_PLAY, S_LHOLD, S_WIN, S_OVER, S_WEND, S_OEND
  } fsm_t;

  localparam longint CNT_CAP = longint'(1) << CNT_W;

  if (HOLD_CYCLES < 2 || longint'(HOLD_CYCLES) > CNT_CAP ||
      END_CYCLES < 2 || longint'(END_CYCLES) > CNT_CAP) begin : g_bad_params
    $error("lcd_state_sequencer: HOLD_CYCLES/END_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  fsm_t             fsm, fsm_nxt;
  logic [7:0]       code_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             to_over, to_over_nxt;
  logic             hold_done;
  logic             chg_nxt;

  assign hold_done = (cnt == HOLD_LAST);

`ifdef LCD_AUTO_RESTART_EN
  localparam logic [CNT_W-1:0] END_LAST = CNT_W'(END_CYCLES - 1);
  logic end_done;
  assign end_done = (cnt == END_LAST);
  assign busy = (fsm == S_AOK) || (fsm == S_AFAIL) || (fsm == S_LHOLD) ||
                (fsm == S_WIN) || (fsm == S_OVER) || (fsm == S_WEND) || (fsm == S_OEND);
`else
  assign busy = (fsm == S_AOK) || (fsm == S_AFAIL) || (fsm == S_LHOLD) ||
                (fsm == S_WIN) || (fsm == S_OVER);
`endif

  // Counter defaults to zero so every hold entry starts fresh; holds count up until done.
  always_comb begin
    fsm_nxt     = fsm;
    code_nxt    = state;
    cnt_nxt     = '0;
    to_over_nxt = to_over;
    case (fsm)
      S_AUTH: begin
        if (auth_fail) begin
          fsm_nxt  = S_AFAIL;
          code_nxt = 8'h02;
        end else if (auth_ok) begin
          fsm_nxt  = S_AOK;
          code_nxt = 8'h01;
        end
      end
      S_AOK: begin
        if (hold_done) begin
          fsm_nxt  = S_PLAY;
          code_nxt = 8'h10;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_AFAIL: begin
        if (hold_done) begin
          fsm_nxt  = S_AUTH;
          code_nxt = 8'h00;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PLAY: begin
        to_over_nxt = 1'b0;
        if (game_over) begin
          fsm_nxt  = S_OVER;
          code_nxt = 8'h30;
        end else if (level_fail && level != 2'd0) begin
          fsm_nxt = S_LHOLD;
          case (level)
            2'd1:    code_nxt = 8'h12;
            2'd2:    code_nxt = 8'h14;
            default: begin
              code_nxt    = 8'h16;
              to_over_nxt = 1'b1;
            end
          endcase
        end else if (level_pass && level != 2'd0) begin
          case (level)
            2'd1: begin
              fsm_nxt  = S_LHOLD;
              code_nxt = 8'h11;
            end
            2'd2: begin
              fsm_nxt  = S_LHOLD;
              code_nxt = 8'h13;
            end
            default: begin
              fsm_nxt  = S_WIN;
              code_nxt = 8'h20;
            end
          endcase
        end
      end
      S_LHOLD: begin
        if (game_over) begin
          fsm_nxt     = S_OVER;
          code_nxt    = 8'h30;
          to_over_nxt = 1'b0;
        end else if (hold_done) begin
          fsm_nxt     = to_over ? S_OVER : S_PLAY;
          code_nxt    = to_over ? 8'h30 : 8'h10;
          to_over_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WIN: begin
        if (hold_done) begin
          fsm_nxt  = S_WEND;
          code_nxt = 8'h21;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_OVER: begin
        if (hold_done) begin
          fsm_nxt  = S_OEND;
          code_nxt = 8'h31;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef LCD_AUTO_RESTART_EN
      S_WEND, S_OEND: begin
        if (end_done) begin
          fsm_nxt  = S_AUTH;
          code_nxt = 8'h00;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`else
      S_WEND, S_OEND: ;
`endif
      default: begin
        fsm_nxt     = S_AUTH;
        code_nxt    = 8'h00;
        to_over_nxt = 1'b0;
      end
    endcase
    chg_nxt = (code_nxt != state);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm       <= S_AUTH;
      state     <= 8'h00;
      state_chg <= 1'b0;
      cnt       <= '0;
      to_over   <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      state     <= code_nxt;
      state_chg <= chg_nxt;
      cnt       <= cnt_nxt;
      to_over   <= to_over_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_state_sequencer.sv
// Bench for lcd_state_sequencer: directed plan scenarios with literal checks, then random events,
// all compared every cycle against a code/remaining-hold model of the display sequence.
module tb_lcd_state_sequencer;

  localparam int HOLD = 10;
  localparam int ENDC = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       auth_ok = 1'b0, auth_fail = 1'b0, level_pass = 1'b0, level_fail = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] level = 2'd0;
  logic [7:0] state;
  logic       state_chg, busy;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  localparam logic [4:0] GO = 5'b10000, LF = 5'b01000, LP = 5'b00100, AF = 5'b00010, AO = 5'b00001;

  lcd_state_sequencer #(.HOLD_CYCLES(HOLD), .END_CYCLES(ENDC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .auth_ok(auth_ok), .auth_fail(auth_fail),
    .level_pass(level_pass), .level_fail(level_fail), .level(level),
    .game_over(game_over), .state(state), .state_chg(state_chg), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: current code, cycles left in its hold, and code shown once the hold ends.
  logic [7:0] m_code = 8'h00, m_next = 8'h00, m_prev;
  int         m_rem = 0;
  logic       m_chg = 1'b0;

  function automatic void enter(input logic [7:0] c, input logic [7:0] nxt, input int dur);
    m_code = c;
    m_next = nxt;
    m_rem  = dur;
  endfunction

  function automatic void arrive(input logic [7:0] c);
    m_rem = 0;
    m_code = c;
    if (c == 8'h30) enter(8'h30, 8'h31, HOLD);
`ifdef LCD_AUTO_RESTART_EN
    if (c == 8'h21 || c == 8'h31) enter(c, 8'h00, ENDC);
`endif
  endfunction

  always @(posedge clk) begin
    m_prev = m_code;
    if (!reset) begin
      m_code = 8'h00;
      m_rem  = 0;
    end else if (m_rem > 0) begin
      if (game_over && (m_code inside {8'h11, 8'h12, 8'h13, 8'h14, 8'h16}))
        enter(8'h30, 8'h31, HOLD);
      else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) arrive(m_next);
      end
    end else if (m_code == 8'h00) begin
      if (auth_fail)    enter(8'h02, 8'h00, HOLD);
      else if (auth_ok) enter(8'h01, 8'h10, HOLD);
    end else if (m_code == 8'h10) begin
      if (game_over) enter(8'h30, 8'h31, HOLD);
      else if (level_fail && level != 0)
        enter(8'h10 + 8'(2 * level), (level == 3) ? 8'h30 : 8'h10, HOLD);
      else if (level_pass && level == 3) enter(8'h20, 8'h21, HOLD);
      else if (level_pass && level != 0) enter(8'h10 + 8'(2 * level - 1), 8'h10, HOLD);
    end
    m_chg = reset && (m_code != m_prev);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors += 3;
      if (state !== m_code) begin
        miscompares++;
        $display("FAIL state @%0t: got %h want %h", $time, state, m_code);
      end
      if (state_chg !== m_chg) begin
        miscompares++;
        $display("FAIL state_chg @%0t: got %b want %b", $time, state_chg, m_chg);
      end
      if (busy !== (m_rem > 0)) begin
        miscompares++;
        $display("FAIL busy @%0t: got %b want %b", $time, busy, (m_rem > 0));
      end
    end
  end

  task automatic drive(input logic [4:0] ev, input logic [1:0] lv);
    @(negedge clk);
    {game_over, level_fail, level_pass, auth_fail, auth_ok} = ev;
    level = lv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(5'b0, 2'd0);
  endtask

  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic to_play();
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    drive(AO, 2'd0);
    idle(11);
    lit("to_play", state, 8'h10);
  endtask

  initial begin
    idle(1);
    chk_en = 1'b1;
    idle(2);
    lit("reset_state", state, 8'h00);
    lit("reset_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;

    drive(AO, 2'd0);
    idle(1);
    lit("aok_code", state, 8'h01);
    lit("aok_chg", {7'd0, state_chg}, 8'h01);
    idle(9);
    lit("aok_last", state, 8'h01);
    lit("aok_busy", {7'd0, busy}, 8'h01);
    idle(1);
    lit("play_code", state, 8'h10);
    lit("play_chg", {7'd0, state_chg}, 8'h01);

    drive(LP, 2'd2);
    idle(1);
    lit("l2pass", state, 8'h13);
    idle(10);
    lit("l2_back", state, 8'h10);
    drive(LP, 2'd3);
    idle(1);
    lit("win", state, 8'h20);
    idle(10);
    lit("wend", state, 8'h21);
    idle(50);
`ifndef LCD_AUTO_RESTART_EN
    lit("wend_terminal", state, 8'h21);
    lit("wend_busy", {7'd0, busy}, 8'h00);
`endif

    to_play();
    drive(LF, 2'd3);
    idle(1);
    lit("l3fail", state, 8'h16);
    idle(10);
    lit("l3_over", state, 8'h30);
    idle(10);
    lit("l3_oend", state, 8'h31);

    to_play();
    drive(LF, 2'd1);
    idle(1);
    lit("l1fail", state, 8'h12);
    idle(2);
    drive(GO, 2'd0);
    idle(1);
    lit("preempt_over", state, 8'h30);
    lit("preempt_chg", {7'd0, state_chg}, 8'h01);
    idle(9);
    lit("preempt_hold", state, 8'h30);
    idle(1);
    lit("preempt_oend", state, 8'h31);
`ifdef LCD_AUTO_RESTART_EN
    idle(14);
    lit("restart_hold", state, 8'h31);
    idle(1);
    lit("restart_auth", state, 8'h00);
    lit("restart_chg", {7'd0, state_chg}, 8'h01);
`endif

    to_play();
    drive(GO | LP, 2'd1);
    idle(1);
    lit("go_beats_pass", state, 8'h30);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    drive(AO | AF, 2'd0);
    idle(1);
    lit("fail_beats_ok", state, 8'h02);
    idle(10);
    lit("afail_back", state, 8'h00);

    to_play();
    drive(LP, 2'd0);
    idle(1);
    lit("lvl0_code", state, 8'h10);
    lit("lvl0_chg", {7'd0, state_chg}, 8'h00);

    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    drive(AO, 2'd0);
    idle(5);
    reset = 1'b0;
    idle(1);
    lit("midhold_reset", state, 8'h00);
    lit("midhold_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      drive({($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 4) == 0)}, 2'($urandom_range(0, 3)));
      reset = ($urandom_range(0, 149) != 0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
